// File: rtl/jsv_cmd.sv
// Avalon-MM write-side PIO toward the Julia-set datapath: static DATA output,
// a valid/ready command channel with sticky overflow, and registered readback.
module jsv_cmd #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 3,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready
);

    // state | meaning
    // IDLE  | no command outstanding
    // PEND  | cmd_data presented to the fabric, waiting for cmd_ready
    typedef enum logic {IDLE, PEND} state_t;

    state_t state_q, state_d;
    logic   overflow;
    logic   load_cmd;
    logic   ovf_set;

    logic wr, wr_data, wr_cmd, wr_stat;
    assign wr      = chipselect && !write_n;
    assign wr_data = wr && (address == 2'd0);
    assign wr_cmd  = wr && (address == 2'd1);
    assign wr_stat = wr && (address == 2'd2);

    assign cmd_valid = (state_q == PEND);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        ovf_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_cmd) begin
                    load_cmd = 1'b1;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (wr_cmd) begin
                    // A write landing on the accepting cycle chains straight in.
                    if (cmd_ready) begin
                        load_cmd = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_DATA;
            cmd_data <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_data) begin
                out_port <= writedata[DATA_W-1:0];
            end
            if (load_cmd) begin
                cmd_data <= writedata[CMD_W-1:0];
            end
            // Set has priority over a same-cycle clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (wr_stat && writedata[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(out_port);
                2'd1:    readdata <= 32'(cmd_data);
                2'd2:    readdata <= {30'b0, overflow, cmd_valid};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_jsv_cmd.sv
// Directed bench for jsv_cmd: register access, command handshake, overflow,
// back-to-back chaining and asynchronous reset while a command is pending.
module tb_jsv_cmd;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [2:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    int total = 0;
    int bad   = 0;

    jsv_cmd #(.DATA_W(8), .CMD_W(3), .RESET_DATA(8'h00)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic pulse_ready;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        cmd_ready  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_port", 32'(out_port), 32'h0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        bus_read(2'd2, rd);
        chk("rst_status", rd, 32'h0);

        // DATA register, upper bits ignored
        bus_write(2'd0, 32'hFFFF_FFA5);
        chk("data_out_port", 32'(out_port), 32'hA5);
        bus_read(2'd0, rd);
        chk("data_read", rd, 32'h0000_00A5);
        bus_read(2'd3, rd);
        chk("reserved_read", rd, 32'h0);

        // cmd_ready while idle does nothing
        @(negedge clk);
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        cmd_ready = 1'b0;
        chk("idle_ready_ignored", 32'(cmd_valid), 32'h0);

        // basic handshake, command held while not ready
        bus_write(2'd1, 32'hFFFF_FFFD);
        chk("hs_valid", 32'(cmd_valid), 32'h1);
        chk("hs_data", 32'(cmd_data), 32'h5);
        repeat (10) @(negedge clk);
        chk("hs_hold_valid", 32'(cmd_valid), 32'h1);
        chk("hs_hold_data", 32'(cmd_data), 32'h5);
        bus_write(2'd0, 32'h3C);
        chk("data_while_pend_out", 32'(out_port), 32'h3C);
        chk("data_while_pend_valid", 32'(cmd_valid), 32'h1);
        bus_read(2'd1, rd);
        chk("hs_cmd_read", rd, 32'h5);
        pulse_ready();
        chk("hs_done_valid", 32'(cmd_valid), 32'h0);
        bus_read(2'd2, rd);
        chk("hs_done_status", rd, 32'h0);

        // overflow: write while pending and not ready
        bus_write(2'd1, 32'h2);
        chk("ovf_pend_data", 32'(cmd_data), 32'h2);
        bus_write(2'd1, 32'h6);
        chk("ovf_data_kept", 32'(cmd_data), 32'h2);
        chk("ovf_valid_kept", 32'(cmd_valid), 32'h1);
        bus_read(2'd2, rd);
        chk("ovf_status", rd, 32'h3);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd);
        chk("ovf_no_clear_bit0", rd, 32'h3);
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, rd);
        chk("ovf_cleared", rd, 32'h1);
        pulse_ready();
        chk("ovf_done_valid", 32'(cmd_valid), 32'h0);

        // back-to-back: new command on the accepting cycle
        bus_write(2'd1, 32'h1);
        chk("b2b_first", 32'(cmd_data), 32'h1);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd1;
        writedata  = 32'h4;
        cmd_ready  = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        cmd_ready  = 1'b0;
        chk("b2b_valid", 32'(cmd_valid), 32'h1);
        chk("b2b_data", 32'(cmd_data), 32'h4);
        bus_read(2'd2, rd);
        chk("b2b_status", rd, 32'h1);

        // async reset while pending
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", 32'(cmd_valid), 32'h0);
        chk("areset_out_port", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        chk("areset_cmd_read", rd, 32'h0);
        chk("areset_valid_after", 32'(cmd_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
